uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, per-packet arbiter that lets two byte streams share one UART transmitter.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   reqN_valid/data/last, reqN_ready - requester N byte offer, end-of-packet mark and accept
//   tx_start, tx_data, tx_busy   - load pulse and byte to the transmitter, frame-in-progress from it
//   grant                        - one-hot owner of the transmitter (zero when idle)
//   abort                        - one-cycle pulse when an owner is dropped for stalling in FETCH
module uart_tx_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_last,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_last,
    output logic                  req1_ready,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_busy,
    output logic [1:0]            grant,
    output logic                  abort
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    typedef enum logic [2:0] {IDLE, FETCH, START, WAIT_BUSY, WAIT_DONE} state_t;
    state_t          state;
    logic            last_q;
    logic            ptr;
    logic [CW-1:0]   cnt;
    logic            pick1;
    logic            hs;
    logic            timeout;
    // ptr=1 means requester 1 wins a tie; it only moves when a packet ends or aborts
    assign pick1      = req1_valid && (!req0_valid || ptr);
    assign req0_ready = (state == FETCH) && grant[0];
    assign req1_ready = (state == FETCH) && grant[1];
    assign hs         = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign timeout    = cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            abort    <= 1'b0;
            last_q   <= 1'b0;
            cnt      <= '0;
            ptr      <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            abort    <= 1'b0;
            case (state)
                IDLE: if (req0_valid || req1_valid) begin
                    grant <= pick1 ? 2'b10 : 2'b01;
                    cnt   <= '0;
                    state <= FETCH;
                end
                FETCH: if (hs) begin
                    tx_data  <= grant[1] ? req1_data : req0_data;
                    last_q   <= grant[1] ? req1_last : req0_last;
                    cnt      <= '0;
                    tx_start <= 1'b1;
                    state    <= START;
                end else if (timeout) begin
                    abort <= 1'b1;
                    grant <= '0;
                    ptr   <= grant[0];
                    state <= IDLE;
                end else if (cnt != '1) begin
                    cnt <= cnt + CW'(1);
                end
                START: state <= WAIT_BUSY;
                WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
                WAIT_DONE: if (!tx_busy) begin
                    if (last_q) begin
                        grant <= '0;
                        ptr   <= grant[0];
                        state <= IDLE;
                    end else begin
                        cnt   <= '0;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
